// File: rtl/y86_pkg.sv
// Y86-64 shared encodings: instruction codes, status codes, register IDs
// and memory-access decode helpers used by the pipeline stages.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    STAT_AOK = 4'h1,
    STAT_HLT = 4'h2,
    STAT_ADR = 4'h3,
    STAT_INS = 4'h4
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
  endfunction

  // POPQ/RET read from the old stack pointer carried in valA.
  function automatic logic addr_from_vala(input logic [3:0] icode);
    return (icode == I_POPQ) || (icode == I_RET);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory stage (master) and DataMem (slave).
interface mem_stage_ctrl_if #(
  parameter int unsigned N = 64
);
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_data;
  logic         mem_rEn;
  logic         mem_wEn;
  logic         dmem_err;

  modport master (
    output mem_addr, mem_data, mem_rEn, mem_wEn,
    input  dmem_err
  );

  modport slave (
    input  mem_addr, mem_data, mem_rEn, mem_wEn,
    output dmem_err
  );
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous active-low reset, stall and
// bubble injection; bubble takes priority over stall.
module pipe_reg #(
  parameter int unsigned     W      = 8,
  parameter logic [W-1:0]    BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         stall_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d = BUBBLE;
    end else if (!stall_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      q_q <= BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage front end: E->M pipeline register plus DataMem address/data/
// enable generation, range check and memory-stage status resolution.
module mem_stage_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter int unsigned MEM_SIZE = 65536
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    E_stat,
  input  logic [3:0]    E_icode,
  input  logic          E_Cnd,
  input  logic [N-1:0]  E_valE,
  input  logic [N-1:0]  E_valA,
  input  logic [3:0]    E_dstE,
  input  logic [3:0]    E_dstM,
  input  logic          M_stall,
  input  logic          M_bubble,
  mem_stage_ctrl_if.master dmem,
  output logic [3:0]    M_icode,
  output logic          M_Cnd,
  output logic [N-1:0]  M_valE,
  output logic [N-1:0]  M_valA,
  output logic [3:0]    M_dstE,
  output logic [3:0]    M_dstM,
  output logic [3:0]    m_stat
);

  localparam int unsigned  MW       = 4 + 4 + 1 + N + N + 4 + 4;
  localparam logic [MW-1:0] M_BUBBLE = {STAT_AOK, I_NOP, 1'b0, {(2*N){1'b0}}, RNONE, RNONE};
  // Highest legal start address for an 8-byte access.
  localparam logic [N-1:0] ADDR_MAX = N'(MEM_SIZE - 8);

  logic [MW-1:0] m_d, m_q;
  logic [3:0]    stat_q;
  logic          rd, wr, rng_err;
  logic [N-1:0]  addr;

  assign m_d = {E_stat, E_icode, E_Cnd, E_valE, E_valA, E_dstE, E_dstM};

  pipe_reg #(
    .W      (MW),
    .BUBBLE (M_BUBBLE)
  ) u_m_reg (
    .clk      (clk),
    .rst_ni   (reset),
    .stall_i  (M_stall),
    .bubble_i (M_bubble),
    .d_i      (m_d),
    .q_o      (m_q)
  );

  assign {stat_q, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM} = m_q;

  always_comb begin
    rd      = is_mem_read(M_icode);
    wr      = is_mem_write(M_icode);
    addr    = addr_from_vala(M_icode) ? M_valA : M_valE;
    rng_err = (rd | wr) & (addr > ADDR_MAX);
  end

  always_comb begin
    dmem.mem_addr = addr;
    dmem.mem_data = M_valA;
    dmem.mem_rEn  = rd & (stat_q == STAT_AOK);
    dmem.mem_wEn  = wr & ~rng_err & (stat_q == STAT_AOK);
    if (rng_err || (dmem.dmem_err && (rd || wr))) begin
      m_stat = STAT_ADR;
    end else begin
      m_stat = stat_q;
    end
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage front end of the pipelined Y86-64 core: holds the E→M pipeline register and drives the data memory's address, data and read/write enables from the registered instruction. Sits directly upstream of `DataMem`, between the execute stage and the write-back register. It merges `DataMem`'s `dmem_err` and its own range check into the memory-stage status. It also exposes M-stage values for forwarding and hazard control.

## Interface
- `N`, 64: data/address width.
- `MEM_SIZE`, 65536: data memory size in bytes; valid accesses satisfy addr+8 ≤ MEM_SIZE.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `E_stat`/`E_icode` input 4/4: status and icode leaving execute.
- `E_Cnd` input 1: condition outcome from execute.
- `E_valE`/`E_valA` input N/N: ALU result; operand A (valP for `call`).
- `E_dstE`/`E_dstM` input 4/4: destination register IDs.
- `M_stall`/`M_bubble` input 1/1: hold / inject bubble, from pipeline control.
- `dmem_err` input 1: error flag returned by `DataMem` for the current access.
- `mem_addr`/`mem_data` output N/N: to `DataMem` `inAdd`/`inData`.
- `mem_rEn`/`mem_wEn` output 1/1: to `DataMem` `rEn`/`wEn`.
- `M_icode`, `M_Cnd`, `M_valE`, `M_valA`, `M_dstE`, `M_dstM` output: registered M values.
- `m_stat` output 4: resolved memory-stage status.

## Operation
- On each edge:
  - `reset`=0: load bubble.
  - Else `M_bubble`=1: load bubble (bubble beats stall).
  - Else `M_stall`=1: hold.
  - Else: load E inputs.
- Bubble/reset contents:
  - stat=AOK(1), icode=NOP(1), Cnd=0.
  - valE=valA=0, dstE=dstM=RNONE(0xF).
- Read for MRMOVQ(5), POPQ(B), RET(9). Write for RMMOVQ(4), PUSHQ(A), CALL(8). Never both.
- `mem_addr` = M_valA for POPQ/RET, else M_valE. `mem_data` = M_valA.
- Range error `rng_err` = (rEn|wEn) & (mem_addr > MEM_SIZE−8); unsigned compare, no wrap.
- `mem_wEn` is forced 0 when `rng_err` or M_stat≠AOK. `mem_rEn` is forced 0 when M_stat≠AOK.
- `m_stat`:
  - ADR(3) if `rng_err` or (`dmem_err` & access).
  - Else M_stat (AOK/HLT(2)/INS(4) pass through).
- All outputs except M register are combinational from M register and `dmem_err`.

## Timing
- Latency: E inputs visible on M outputs one cycle after the capturing edge.
- `mem_*` are valid throughout the cycle. `DataMem` samples writes at the next rising edge.
- `dmem_err` is consumed in the same cycle it is presented.
- Reset values: `mem_addr`=`mem_data`=0, `mem_rEn`=`mem_wEn`=0, `m_stat`=AOK, `M_icode`=NOP, `M_dstE`=`M_dstM`=0xF, `M_Cnd`=0.
- Stall holds all outputs bit-stable. A write under stall is re-presented each cycle; pipeline control must not stall a write.
- Reset mid-access: the next edge clears the register; `mem_wEn` drops in that cycle.
- Boundary: addr=MEM_SIZE−8 is legal; MEM_SIZE−7 gives ADR.

## Structure
- Package `y86_pkg`:
  - icode constants.
  - stat codes AOK/HLT/ADR/INS.
  - RNONE.
  - `is_mem_read` / `is_mem_write` functions.
- Sub-module `pipe_reg`: parameterised width, stall/bubble/reset, bubble value as parameter. Reused for other stage registers.
- Control and status logic stay in `mem_stage_ctrl`.

## Test plan
- Reset low for 2 cycles, then high with no stimulus → bubble values on all outputs, `mem_rEn`=`mem_wEn`=0, `m_stat`=1.
- RMMOVQ, valE=0x100, valA=0xDEAD → next cycle: `mem_addr`=0x100, `mem_data`=0xDEAD, `wEn`=1, `rEn`=0, `m_stat`=1.
- POPQ, valA=0x200, valE=0x208 → `mem_addr`=0x200, `rEn`=1.
- RMMOVQ, valE=0xFFF9 → `wEn`=0, `m_stat`=3. Same with valE=0xFFF8 → `wEn`=1, `m_stat`=1.
- MRMOVQ in range with `dmem_err`=1 → `m_stat`=3. HLT-status instruction → `rEn`=`wEn`=0, `m_stat`=2.
- `M_stall`=1 for 3 cycles → outputs frozen. `M_stall`=`M_bubble`=1 → bubble loaded.
